// File: rtl/clk_meas_pkg.sv
// ---------------------------------------------------------------------------
// clk_meas_pkg
// Shared definitions for the slow-clock period meter:
//   - meas_state_e : measurement FSM states (2-bit encoding)
//   - SYNC_STAGES  : depth of the metastability synchroniser on slow_in
// ---------------------------------------------------------------------------
package clk_meas_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,  // waiting for the first rising edge
    MEASURE = 2'd1,  // previous rising edge known, counting
    STALLED = 2'd2   // no rising edge for TIMEOUT cycles
  } meas_state_e;

endpackage

// File: rtl/edge_sync.sv
// ---------------------------------------------------------------------------
// edge_sync
// Brings an asynchronous level into the clk domain through a SYNC_STAGES-deep
// flop chain, then keeps one history flop so edges can be detected as
// single-cycle pulses.
// Ports:
//   clk     in  system clock
//   rst_n   in  synchronous active-low reset (clears every flop)
//   async_i in  asynchronous input level
//   rise_o  out one-cycle pulse on a synchronised 0->1 transition
//   fall_o  out one-cycle pulse on a synchronised 1->0 transition
// ---------------------------------------------------------------------------
module edge_sync
  import clk_meas_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  // sync_q[0] is the first (possibly metastable) stage; the last entry is
  // the clean synchronised level.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   level;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level  = sync_q[SYNC_STAGES-1];
  assign rise_o = level & ~hist_q;
  assign fall_o = ~level & hist_q;

endmodule

// File: rtl/clk_period_meter.sv
// ---------------------------------------------------------------------------
// clk_period_meter
// Measures a slow square wave in units of clk: period between successive
// rising edges and high time from a rising edge to the following falling
// edge. Declares a stall when no rising edge arrives for TIMEOUT cycles.
// Ports:
//   clk       in  system clock
//   rst_n     in  synchronous active-low reset
//   slow_in   in  asynchronous slow square wave
//   period    out cycles between the last two rising edges
//   high_time out cycles from rising edge to following falling edge
//   valid     out one-cycle strobe when period/high_time update
//   stalled   out level, high while the input has stopped toggling
// ---------------------------------------------------------------------------
module clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             slow_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             stalled
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(TIMEOUT - 1);

  logic rise;
  logic fall;

  edge_sync u_edge_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (slow_in),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  meas_state_e      state_q,  state_d;
  logic [WIDTH-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] hcap_q,   hcap_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_q,   high_d;
  logic             valid_q,  valid_d;
  logic [WIDTH-1:0] cnt_inc;

  // cnt holds (cycles since last rise - 1), so +1 gives the edge distance.
  // It saturates at TIMEOUT-1, hence cnt_inc never exceeds TIMEOUT.
  assign cnt_inc = cnt_q + WIDTH'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hcap_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcap_q   <= hcap_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hcap_d   = hcap_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;

    if (rise) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_inc;
    end

    // rise is checked before saturation everywhere so an edge arriving on
    // the saturation cycle still counts as activity.
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = MEASURE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = STALLED;
        end
      end
      MEASURE: begin
        if (fall) begin
          hcap_d = cnt_inc;
        end
        if (rise) begin
          period_d = cnt_inc;
          high_d   = hcap_q;
          valid_d  = 1'b1;
        end else if (cnt_q == CNT_MAX) begin
          state_d = STALLED;
        end
      end
      STALLED: begin
        // The edge before this rise is unknown, so no measurement here.
        if (rise) begin
          state_d = MEASURE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign stalled   = (state_q == STALLED);

endmodule

// File: tb/tb_clk_period_meter.sv
// ---------------------------------------------------------------------------
// tb_clk_period_meter
// Bench for clk_period_meter (WIDTH=32, TIMEOUT=100). Stimulus tasks drive
// slow_in one clk cycle at a time; every rising edge that should produce a
// measurement pushes the expected period/high time (taken from the cycle
// numbers the bench itself used) onto a queue, which the valid monitor pops.
// ---------------------------------------------------------------------------
module tb_clk_period_meter;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 100;

  typedef struct packed {
    logic [31:0] period;
    logic [31:0] high;
  } exp_t;

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b0;
  logic             slow_in = 1'b0;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             valid;
  logic             stalled;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec     = 0;
  int   n_err     = 0;
  int   cyc       = 0;
  int   last_rise = 0;
  int   last_fall = 0;
  bit   armed     = 1'b0;

  clk_period_meter #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .slow_in   (slow_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .stalled   (stalled)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer: every valid must match the oldest expectation.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_valid: got period=%0d high_time=%0d, required no valid (cyc %0d)",
                 period, high_time, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (period !== mon_e.period || high_time !== mon_e.high) begin
          n_err++;
          $display("FAIL measurement: got period=%0d high_time=%0d, required period=%0d high_time=%0d (cyc %0d)",
                   period, high_time, mon_e.period, mon_e.high, cyc);
        end else begin
          $display("valid: period=%0d high_time=%0d (cyc %0d)", period, high_time, cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive slow_in for the coming cycle; a rising edge after a known rising
  // edge yields an expected measurement.
  task automatic drive_level(input logic v);
    exp_t e;
    if (v && !slow_in) begin
      if (armed) begin
        e.period = 32'(cyc - last_rise);
        e.high   = 32'(last_fall - last_rise);
        exp_q.push_back(e);
      end
      armed     = 1'b1;
      last_rise = cyc;
    end else if (!v && slow_in) begin
      last_fall = cyc;
    end
    slow_in = v;
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      drive_level(1'b1);
      repeat (hi) tick();
      drive_level(1'b0);
      repeat (lo) tick();
    end
  endtask

  task automatic check_drained(input string name);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drained: got %0d pending measurements, required 0", name, exp_q.size());
    end
  endtask

  task automatic check_outputs(input string name, input logic [31:0] p,
                               input logic [31:0] h, input logic v, input logic s);
    n_vec++;
    if (period !== p) begin
      n_err++;
      $display("FAIL %s_period: got %0d, required %0d", name, period, p);
    end
    n_vec++;
    if (high_time !== h) begin
      n_err++;
      $display("FAIL %s_high_time: got %0d, required %0d", name, high_time, h);
    end
    n_vec++;
    if (valid !== v) begin
      n_err++;
      $display("FAIL %s_valid: got %0b, required %0b", name, valid, v);
    end
    n_vec++;
    if (stalled !== s) begin
      n_err++;
      $display("FAIL %s_stalled: got %0b, required %0b", name, stalled, s);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    slow_in = 1'b0;
    armed   = 1'b0;
    exp_q.delete();
    repeat (3) tick();
    check_outputs("reset_held", 32'd0, 32'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (20) tick();
    check_outputs("reset_idle", 32'd0, 32'd0, 1'b0, 1'b0);
    $display("test_reset done");
  endtask

  task automatic test_div4();
    wave(4, 4, 6);
    check_outputs("div4", 32'd8, 32'd4, 1'b0, 1'b0);
    check_drained("div4");
    $display("test_div4 done");
  endtask

  task automatic test_asym();
    wave(3, 7, 4);
    check_outputs("asym", 32'd10, 32'd3, 1'b0, 1'b0);
    check_drained("asym");
    $display("test_asym done");
  endtask

  task automatic test_stall();
    wave(4, 4, 3);
    // Rise detected 3 edges after it is driven; stall 100 edges after that.
    while (cyc < last_rise + 3 + TIMEOUT - 1) tick();
    check_outputs("pre_stall", 32'd8, 32'd4, 1'b0, 1'b0);
    tick();
    check_outputs("stall", 32'd8, 32'd4, 1'b0, 1'b1);
    check_drained("stall");
    armed = 1'b0;
    drive_level(1'b1);
    repeat (2) tick();
    n_vec++;
    if (stalled !== 1'b1) begin
      n_err++;
      $display("FAIL stall_hold: got stalled=%0b, required 1", stalled);
    end
    tick();
    n_vec++;
    if (stalled !== 1'b0) begin
      n_err++;
      $display("FAIL stall_clear: got stalled=%0b, required 0", stalled);
    end
    repeat (2) tick();
    drive_level(1'b0);
    repeat (5) tick();
    wave(5, 5, 2);
    check_outputs("recover", 32'd10, 32'd5, 1'b0, 1'b0);
    check_drained("recover");
    $display("test_stall done");
  endtask

  task automatic test_reset_mid();
    wave(4, 4, 2);
    drive_level(1'b1);
    repeat (4) tick();
    drive_level(1'b0);
    repeat (3) tick();
    check_drained("pre_reset_mid");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    armed = 1'b0;
    check_outputs("reset_mid", 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    wave(4, 4, 3);
    check_outputs("post_reset_mid", 32'd8, 32'd4, 1'b0, 1'b0);
    check_drained("post_reset_mid");
    $display("test_reset_mid done");
  endtask

  task automatic test_rate_change();
    wave(4, 4, 2);
    wave(4, 6, 1);
    wave(6, 6, 3);
    check_outputs("rate_change", 32'd12, 32'd6, 1'b0, 1'b0);
    check_drained("rate_change");
    $display("test_rate_change done");
  endtask

  initial begin
    test_reset();
    test_div4();
    test_asym();
    test_stall();
    test_reset_mid();
    test_rate_change();
    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
